// File: rtl/draw_pkg.sv
// ---------------------------------------------------------------------------
// draw_pkg: shared definitions for the VGA drawing-path blocks.
//   - draw_state_e : blitter FSM state encoding (IDLE, RUN, DRAIN, DONE)
//   - default screen geometry and bus widths for a 320x240, 3-bit colour
//     VGA adapter
//   - colour constants, including the default transparent key colour
//   - cnt_bits()   : counter width for a 0..n-1 range, never less than 1
// ---------------------------------------------------------------------------
package draw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } draw_state_e;

  localparam int SCREEN_W_DEF    = 320;
  localparam int SCREEN_H_DEF    = 240;
  localparam int X_BITS_DEF      = 9;
  localparam int Y_BITS_DEF      = 8;
  localparam int COLOUR_BITS_DEF = 3;

  localparam logic [2:0] COLOUR_BLACK = 3'd0;
  localparam logic [2:0] COLOUR_WHITE = 3'd7;

  // Black is the background colour, so it doubles as the default key.
  localparam int KEY_COLOUR_DEF = int'(COLOUR_BLACK);

  // Width of a counter spanning 0..n-1; a 1-wide range still needs 1 bit.
  function automatic int cnt_bits(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/draw_scan_counter.sv
// ---------------------------------------------------------------------------
// draw_scan_counter: raster scan counter for an IMG_W x IMG_H image.
//   cx runs fastest, cy steps when cx wraps, and address tracks
//   cy*IMG_W + cx as a plain incrementing counter (no multiplier).
// Ports:
//   clock_all  in   system clock, rising edge
//   reset_all  in   synchronous active-high reset
//   clear      in   restart the scan at pixel 0 on the next edge
//   advance    in   step to the next pixel on the next edge
//   cx, cy     out  current pixel coordinates inside the image
//   address    out  linear pixel index (registered)
//   last       out  current pixel is the bottom-right one
// ---------------------------------------------------------------------------
module draw_scan_counter
  import draw_pkg::*;
#(
  parameter int IMG_W     = 320,
  parameter int IMG_H     = 240,
  parameter int ADDR_BITS = 17
) (
  input  logic                           clock_all,
  input  logic                           reset_all,
  input  logic                           clear,
  input  logic                           advance,
  output logic [cnt_bits(IMG_W)-1:0]     cx,
  output logic [cnt_bits(IMG_H)-1:0]     cy,
  output logic [ADDR_BITS-1:0]           address,
  output logic                           last
);

  localparam int CX_BITS = cnt_bits(IMG_W);
  localparam int CY_BITS = cnt_bits(IMG_H);
  localparam logic [CX_BITS-1:0] CX_MAX = CX_BITS'(IMG_W - 1);
  localparam logic [CY_BITS-1:0] CY_MAX = CY_BITS'(IMG_H - 1);

  logic cx_end_s;
  logic cy_end_s;

  assign cx_end_s = (cx == CX_MAX);
  assign cy_end_s = (cy == CY_MAX);
  assign last     = cx_end_s & cy_end_s;

  // Raster stepping: cx wraps into cy; the whole scan wraps back to pixel 0.
  always_ff @(posedge clock_all) begin
    if (reset_all || clear) begin
      cx      <= '0;
      cy      <= '0;
      address <= '0;
    end else if (advance) begin
      if (cx_end_s) begin
        cx <= '0;
        if (cy_end_s) begin
          cy      <= '0;
          address <= '0;
        end else begin
          cy      <= cy + 1'b1;
          address <= address + 1'b1;
        end
      end else begin
        cx      <= cx + 1'b1;
        address <= address + 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_sprite.sv
// ---------------------------------------------------------------------------
// draw_sprite: image blitter for the VGA drawing path.
//   On an accepted start it reads an IMG_W x IMG_H image from an external
//   ROM (one address per clock) and emits screen coordinates, colour and a
//   plot strobe aligned to the ROM read latency. Pixels falling off the
//   visible screen keep their slot but are not plotted.
// Optional feature (macro DRAW_SPRITE_TRANSPARENT_EN): pixels whose colour
//   equals KEY_COLOUR are not plotted; timing is unchanged.
// Ports:
//   clock_all    in   system clock, rising edge
//   reset_all    in   synchronous active-high reset (beats everything)
//   start        in   draw request, only looked at while idle
//   x_, y_       in   image origin, captured when start is accepted
//   rom_address  out  ROM read address (registered)
//   rom_q        in   ROM data, ROM_LATENCY clocks after its address
//   out_x/out_y  out  pixel screen coordinates (hold between pixels)
//   out_colour   out  pixel colour straight from rom_q (hold between pixels)
//   plot         out  frame-buffer write strobe
//   busy         out  high from accepted start through the done cycle
//   done         out  one-cycle pulse after the last pixel slot
// ---------------------------------------------------------------------------
module draw_sprite
  import draw_pkg::*;
#(
  parameter int IMG_W       = 320,
  parameter int IMG_H       = 240,
  parameter int SCREEN_W    = SCREEN_W_DEF,
  parameter int SCREEN_H    = SCREEN_H_DEF,
  parameter int X_BITS      = X_BITS_DEF,
  parameter int Y_BITS      = Y_BITS_DEF,
  parameter int COLOUR_BITS = COLOUR_BITS_DEF,
  parameter int ADDR_BITS   = 17,
  parameter int ROM_LATENCY = 1,
  parameter int KEY_COLOUR  = KEY_COLOUR_DEF
) (
  input  logic                   clock_all,
  input  logic                   reset_all,
  input  logic                   start,
  input  logic [X_BITS-1:0]      x_,
  input  logic [Y_BITS-1:0]      y_,
  output logic [ADDR_BITS-1:0]   rom_address,
  input  logic [COLOUR_BITS-1:0] rom_q,
  output logic [X_BITS-1:0]      out_x,
  output logic [Y_BITS-1:0]      out_y,
  output logic [COLOUR_BITS-1:0] out_colour,
  output logic                   plot,
  output logic                   busy,
  output logic                   done
);

  localparam int CX_BITS    = cnt_bits(IMG_W);
  localparam int CY_BITS    = cnt_bits(IMG_H);
  // One spare bit so origin + offset never overflows before the clip test.
  localparam int XS_BITS    = ((X_BITS > CX_BITS) ? X_BITS : CX_BITS) + 1;
  localparam int YS_BITS    = ((Y_BITS > CY_BITS) ? Y_BITS : CY_BITS) + 1;
  localparam int DRAIN_BITS = cnt_bits(ROM_LATENCY);
  localparam int LAST       = ROM_LATENCY - 1;
  localparam logic [COLOUR_BITS-1:0] KEY_S = COLOUR_BITS'(KEY_COLOUR);

  draw_state_e            state_r;
  draw_state_e            state_next_s;
  logic [X_BITS-1:0]      origin_x_r;
  logic [Y_BITS-1:0]      origin_y_r;
  logic [DRAIN_BITS-1:0]  drain_cnt_r;
  logic                   accept_s;
  logic                   issue_s;
  logic                   last_s;
  logic [CX_BITS-1:0]     cx_s;
  logic [CY_BITS-1:0]     cy_s;
  logic [XS_BITS-1:0]     x_sum_s;
  logic [YS_BITS-1:0]     y_sum_s;
  logic                   on_screen_s;
  logic                   busy_r;
  logic                   done_r;
  logic [COLOUR_BITS-1:0] colour_hold_r;

  // Coordinate pipeline, stage LAST lines up with rom_q.
  logic                   pipe_valid_r [ROM_LATENCY];
  logic                   pipe_ok_r    [ROM_LATENCY];
  logic [X_BITS-1:0]      pipe_x_r     [ROM_LATENCY];
  logic [Y_BITS-1:0]      pipe_y_r     [ROM_LATENCY];

  assign accept_s = (state_r == ST_IDLE) && start;
  assign issue_s  = (state_r == ST_RUN);

  draw_scan_counter #(
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .ADDR_BITS (ADDR_BITS)
  ) u_scan (
    .clock_all (clock_all),
    .reset_all (reset_all),
    .clear     (accept_s),
    .advance   (issue_s),
    .cx        (cx_s),
    .cy        (cy_s),
    .address   (rom_address),
    .last      (last_s)
  );

  // Clip on the untruncated sum so coordinates that wrap are never plotted.
  assign x_sum_s     = XS_BITS'(origin_x_r) + XS_BITS'(cx_s);
  assign y_sum_s     = YS_BITS'(origin_y_r) + YS_BITS'(cy_s);
  assign on_screen_s = (int'(x_sum_s) < SCREEN_W) && (int'(y_sum_s) < SCREEN_H);

  // Next-state logic of the draw sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      // DRAIN lasts ROM_LATENCY cycles so DONE follows the last plot slot.
      ST_DRAIN: begin
        if (drain_cnt_r == DRAIN_BITS'(ROM_LATENCY - 1)) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register plus registered busy/done decoded from the next state.
  always_ff @(posedge clock_all) begin
    if (reset_all) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
      done_r  <= (state_next_s == ST_DONE);
    end
  end

  // Cycles spent in DRAIN so far.
  always_ff @(posedge clock_all) begin
    if (reset_all) begin
      drain_cnt_r <= '0;
    end else if (state_r == ST_DRAIN) begin
      drain_cnt_r <= drain_cnt_r + 1'b1;
    end else begin
      drain_cnt_r <= '0;
    end
  end

  // Image origin captured on the accepted start.
  always_ff @(posedge clock_all) begin
    if (reset_all) begin
      origin_x_r <= '0;
      origin_y_r <= '0;
    end else if (accept_s) begin
      origin_x_r <= x_;
      origin_y_r <= y_;
    end
  end

  // Shift (coords, clip result, valid) along with the ROM read latency;
  // coordinates only move with a valid pixel so outputs hold in gaps.
  always_ff @(posedge clock_all) begin
    if (reset_all) begin
      for (int i = 0; i < ROM_LATENCY; i++) begin
        pipe_valid_r[i] <= 1'b0;
        pipe_ok_r[i]    <= 1'b0;
        pipe_x_r[i]     <= '0;
        pipe_y_r[i]     <= '0;
      end
    end else begin
      pipe_valid_r[0] <= issue_s;
      pipe_ok_r[0]    <= issue_s & on_screen_s;
      if (issue_s) begin
        pipe_x_r[0] <= x_sum_s[X_BITS-1:0];
        pipe_y_r[0] <= y_sum_s[Y_BITS-1:0];
      end
      for (int i = 1; i < ROM_LATENCY; i++) begin
        pipe_valid_r[i] <= pipe_valid_r[i-1];
        pipe_ok_r[i]    <= pipe_ok_r[i-1];
        if (pipe_valid_r[i-1]) begin
          pipe_x_r[i] <= pipe_x_r[i-1];
          pipe_y_r[i] <= pipe_y_r[i-1];
        end
      end
    end
  end

  // Last pixel colour, shown while no pixel is in flight.
  always_ff @(posedge clock_all) begin
    if (reset_all) begin
      colour_hold_r <= '0;
    end else if (pipe_valid_r[LAST]) begin
      colour_hold_r <= rom_q;
    end
  end

  assign out_x      = pipe_x_r[LAST];
  assign out_y      = pipe_y_r[LAST];
  assign out_colour = pipe_valid_r[LAST] ? rom_q : colour_hold_r;
  assign busy       = busy_r;
  assign done       = done_r;

`ifdef DRAW_SPRITE_TRANSPARENT_EN
  assign plot = pipe_ok_r[LAST] & (rom_q != KEY_S);
`else
  logic unused_key_s;
  assign unused_key_s = ^KEY_S;
  assign plot = pipe_ok_r[LAST];
`endif

endmodule

// File: tb/tb_draw_sprite.sv
// ---------------------------------------------------------------------------
// tb_draw_sprite: randomized scoreboard bench for draw_sprite (4x3 image,
// ROM latency 3). Each draw pushes its expected plots, done pulse and busy
// window into queues; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_draw_sprite;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int N   = W * H;
  localparam int L   = 3;
  localparam int XB  = 9;
  localparam int YB  = 8;
  localparam int CB  = 3;
  localparam int AB  = 17;
  localparam int SW  = 320;
  localparam int SH  = 240;
  localparam int KEY = 0;

  logic          clock_all = 1'b0;
  logic          reset_all;
  logic          start;
  logic [XB-1:0] x_;
  logic [YB-1:0] y_;
  logic [AB-1:0] rom_address;
  logic [CB-1:0] rom_q;
  logic [XB-1:0] out_x;
  logic [YB-1:0] out_y;
  logic [CB-1:0] out_colour;
  logic          plot;
  logic          busy;
  logic          done;

  always #5 clock_all = ~clock_all;

  draw_sprite #(
    .IMG_W(W), .IMG_H(H), .SCREEN_W(SW), .SCREEN_H(SH), .X_BITS(XB), .Y_BITS(YB),
    .COLOUR_BITS(CB), .ADDR_BITS(AB), .ROM_LATENCY(L), .KEY_COLOUR(KEY)
  ) dut (
    .clock_all(clock_all), .reset_all(reset_all), .start(start), .x_(x_), .y_(y_),
    .rom_address(rom_address), .rom_q(rom_q), .out_x(out_x), .out_y(out_y),
    .out_colour(out_colour), .plot(plot), .busy(busy), .done(done)
  );

  // Cycle number: the interval after rising edge e reads cyc == e.
  int cyc = 0;
  always @(posedge clock_all) cyc <= cyc + 1;

  // External ROM with L clocks of read latency.
  logic [CB-1:0] mem [N];
  logic [CB-1:0] rom_pipe [L];
  always @(posedge clock_all) begin
    rom_pipe[0] <= (int'(rom_address) < N) ? mem[int'(rom_address)] : '0;
    for (int i = 1; i < L; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_q = rom_pipe[L-1];

  typedef struct {
    int cyc;
    int x;
    int y;
    int c;
  } pix_t;

  pix_t exp_q[$];
  int   done_q[$];
  int   busy_lo_q[$];
  int   busy_hi_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  pix_t mon_e;
  bit   mon_busy;

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0d required %0d", name, cyc, got, req);
    end
  endtask

  // Scoreboard monitor: compares every plot, done and busy sample.
  always @(negedge clock_all) begin
    if (mon_en) begin
      if (plot === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL plot_unexpected at cyc %0d: got (%0d,%0d) c=%0d required no plot",
                   cyc, out_x, out_y, out_colour);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.cyc != cyc || mon_e.x != int'(out_x) || mon_e.y != int'(out_y) ||
              mon_e.c != int'(out_colour)) begin
            errors++;
            $display("FAIL plot_pixel: got cyc %0d (%0d,%0d) c=%0d required cyc %0d (%0d,%0d) c=%0d",
                     cyc, out_x, out_y, out_colour, mon_e.cyc, mon_e.x, mon_e.y, mon_e.c);
          end
        end
      end else if (plot !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL plot_unknown at cyc %0d: got %b required 0/1", cyc, plot);
      end
      if (done !== 1'b0) begin
        checks++;
        if (done_q.size() == 0 || done_q[0] != cyc || done !== 1'b1) begin
          errors++;
          $display("FAIL done_pulse at cyc %0d: got %b required cyc %0d", cyc, done,
                   (done_q.size() > 0) ? done_q[0] : -1);
        end
        if (done_q.size() > 0) void'(done_q.pop_front());
      end
      while (busy_hi_q.size() > 0 && busy_hi_q[0] < cyc) begin
        void'(busy_hi_q.pop_front());
        void'(busy_lo_q.pop_front());
      end
      mon_busy = (busy_lo_q.size() > 0) && (busy_lo_q[0] <= cyc);
      checks++;
      if (busy !== mon_busy) begin
        errors++;
        $display("FAIL busy at cyc %0d: got %b required %b", cyc, busy, mon_busy);
      end
    end
  end

  // Reference model: a draw accepted at edge a addresses pixel p during
  // cycle a+p and presents it L cycles later; done follows the last slot.
  // With cut set, a reset takes effect after cycle cut_cyc.
  task automatic push_draw(input int a, input int ox, input int oy, input bit cut, input int cut_cyc);
    pix_t e;
    for (int p = 0; p < N; p++) begin
      int xs = ox + (p % W);
      int ys = oy + (p / W);
      bit vis = (xs < SW) && (ys < SH);
`ifdef DRAW_SPRITE_TRANSPARENT_EN
      vis = vis && (mem[p] != CB'(KEY));
`endif
      if (vis && (!cut || (a + p + L <= cut_cyc))) begin
        e.cyc = a + p + L;
        e.x   = xs % (1 << XB);
        e.y   = ys % (1 << YB);
        e.c   = int'(mem[p]);
        exp_q.push_back(e);
      end
    end
    if (!cut) done_q.push_back(a + N + L);
    busy_lo_q.push_back(a);
    busy_hi_q.push_back(cut ? cut_cyc : a + N + L);
  endtask

  // 0: random, 1: colour = address[2:0], 2: all zero except address 5 = 3
  task automatic fill_rom(input int mode);
    for (int p = 0; p < N; p++) begin
      case (mode)
        1:       mem[p] = CB'(p);
        2:       mem[p] = (p == 5) ? 3'd3 : 3'd0;
        default: mem[p] = CB'($urandom);
      endcase
    end
  endtask

  task automatic drain_checks(input string tag);
    chk({tag, "_plots_left"}, exp_q.size(), 0);
    chk({tag, "_done_left"}, done_q.size(), 0);
  endtask

  // One draw, called on a falling edge; optionally pokes start mid-draw.
  task automatic do_draw(input int ox, input int oy, input int mode, input bit poke);
    int a;
    int k;
    fill_rom(mode);
    x_ = XB'(ox);
    y_ = YB'(oy);
    start = 1'b1;
    a = cyc + 1;
    push_draw(a, ox, oy, 1'b0, 0);
    @(negedge clock_all);
    start = 1'b0;
    if (poke) begin
      k = $urandom_range(0, N + L - 1);
      repeat (1 + k) @(negedge clock_all);
      start = 1'b1;
      x_ = XB'($urandom);
      y_ = YB'($urandom);
      @(negedge clock_all);
      start = 1'b0;
      repeat (N + L - 1 - k) @(negedge clock_all);
    end else begin
      repeat (N + L + 1) @(negedge clock_all);
    end
    drain_checks("draw");
  endtask

  initial begin
    int a;
    reset_all = 1'b1;
    start = 1'b0;
    x_ = '0;
    y_ = '0;
    fill_rom(1);
    repeat (3) @(negedge clock_all);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_plot", int'(plot), 0);
    chk("reset_rom_address", int'(rom_address), 0);
    chk("reset_out_x", int'(out_x), 0);
    chk("reset_out_y", int'(out_y), 0);
    chk("reset_out_colour", int'(out_colour), 0);
    reset_all = 1'b0;
    mon_en = 1'b1;
    @(negedge clock_all);

    // Directed draws: plain, bottom-right corner, wrapping x, key-colour ROM.
    do_draw(10, 20, 1, 1'b0);
    do_draw(318, 239, 0, 1'b0);
    do_draw(510, 5, 0, 1'b0);
    do_draw(40, 50, 2, 1'b0);
    do_draw(0, 0, 0, 1'b1);

    // start held high across a whole draw: exactly one restart after done.
    fill_rom(0);
    x_ = 9'd100;
    y_ = 8'd60;
    start = 1'b1;
    a = cyc + 1;
    push_draw(a, 100, 60, 1'b0, 0);
    push_draw(a + N + L + 2, 100, 60, 1'b0, 0);
    @(negedge clock_all);
    repeat (N + L + 2) @(negedge clock_all);
    start = 1'b0;
    repeat (N + L + 1) @(negedge clock_all);
    drain_checks("hold");

    // Reset during the 6th pixel cycle, then a fresh draw from pixel 0.
    fill_rom(1);
    x_ = 9'd10;
    y_ = 8'd20;
    start = 1'b1;
    a = cyc + 1;
    push_draw(a, 10, 20, 1'b1, a + 5);
    @(negedge clock_all);
    start = 1'b0;
    repeat (5) @(negedge clock_all);
    reset_all = 1'b1;
    @(negedge clock_all);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_plot", int'(plot), 0);
    chk("midreset_done", int'(done), 0);
    reset_all = 1'b0;
    repeat (N + L + 2) @(negedge clock_all);
    drain_checks("midreset");
    do_draw(10, 20, 1, 1'b0);

    // Randomized draws around the screen edges and the wrap region.
    for (int t = 0; t < 16; t++) begin
      int ox;
      int oy;
      case ($urandom_range(0, 2))
        0:       begin ox = $urandom_range(0, 330); oy = $urandom_range(0, 245); end
        1:       begin ox = $urandom_range(314, 319); oy = $urandom_range(235, 239); end
        default: begin ox = $urandom_range(0, 511); oy = $urandom_range(0, 255); end
      endcase
      do_draw(ox, oy, 0, bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clock_all);
    end

    repeat (4) @(negedge clock_all);
    drain_checks("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
